// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one external ALU between two requesters
module alu_arbiter #(
  parameter int WIDTH   = 64,
  parameter int CNTRL_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [CNTRL_W-1:0] req0_cntrl,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [CNTRL_W-1:0] req1_cntrl,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [WIDTH-1:0]   resp_result,
  output logic [3:0]         resp_flags,
  output logic               busy,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [CNTRL_W-1:0] alu_cntrl,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_negative,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  input  logic               alu_carry_out
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t             state;
  logic               last_grant;
  logic               owner;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [CNTRL_W-1:0] op_cntrl;
  logic [1:0]         grant;
  logic               owner_ready;

  // Round-robin pick: on a tie the requester not served last time wins
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req_valid;
    end
  end

  // Accept only in IDLE; masked during reset so nothing is accepted that cycle
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !reset) begin
      req_ready = grant;
    end
  end

  // Response handshake is only ever taken from the current owner
  always_comb begin
    owner_ready = owner ? resp_ready[1] : resp_ready[0];
  end

  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_cntrl = op_cntrl;

  // Transaction FSM with registered operands, results and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_cntrl    <= '0;
      resp_result <= '0;
      resp_flags  <= 4'b0000;
      resp_valid  <= 2'b00;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            owner      <= grant[1];
            last_grant <= grant[1];
            op_a       <= grant[1] ? req1_a : req0_a;
            op_b       <= grant[1] ? req1_b : req0_b;
            op_cntrl   <= grant[1] ? req1_cntrl : req0_cntrl;
            state      <= EXEC;
            busy       <= 1'b1;
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_flags  <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
          resp_valid  <= owner ? 2'b10 : 2'b01;
          state       <= RESP;
        end
        RESP: begin
          if (owner_ready) begin
            resp_valid <= 2'b00;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 2'b00;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed-vector bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_cntrl, req1_cntrl;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [63:0] resp_result;
  logic [3:0]  resp_flags;
  logic        busy;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_cntrl;
  logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cntrl(req0_cntrl),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cntrl(req1_cntrl),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out)
  );

  // Behavioural 64-bit ALU attached to the arbiter
  logic c_out, v_out;
  always_comb begin
    alu_result = '0;
    c_out      = 1'b0;
    v_out      = 1'b0;
    case (alu_cntrl)
      3'b000: alu_result = alu_b;
      3'b010: begin
        {c_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
        v_out = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
      end
      3'b011: begin
        {c_out, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
        v_out = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_a[63]);
      end
      3'b100: alu_result = alu_a & alu_b;
      3'b101: alu_result = alu_a | alu_b;
      3'b110: alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
    alu_negative  = alu_result[63];
    alu_zero      = (alu_result == 64'd0);
    alu_overflow  = v_out;
    alu_carry_out = c_out;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction from requester who; starts and ends just after a rising edge
  task automatic do_txn(input int who, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res,
                        input logic [3:0] exp_flags, input string tag);
    logic [1:0] sel;
    sel = (who == 1) ? 2'b10 : 2'b01;
    if (who == 1) begin
      req1_a = a; req1_b = b; req1_cntrl = op;
    end else begin
      req0_a = a; req0_b = b; req0_cntrl = op;
    end
    req_valid = sel;
    @(negedge clk);
    check({tag, " req_ready"}, 64'(req_ready), 64'(sel));
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    check({tag, " exec busy"}, 64'(busy), 64'd1);
    check({tag, " exec resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, " alu_a"}, alu_a, a);
    check({tag, " alu_b"}, alu_b, b);
    check({tag, " alu_cntrl"}, 64'(alu_cntrl), 64'(op));
    next_cycle();
    @(negedge clk);
    check({tag, " resp_valid"}, 64'(resp_valid), 64'(sel));
    check({tag, " result"}, resp_result, exp_res);
    check({tag, " flags"}, 64'(resp_flags), 64'(exp_flags));
    resp_ready = sel;
    next_cycle();
    resp_ready = 2'b00;
    @(negedge clk);
    check({tag, " done busy"}, 64'(busy), 64'd0);
    check({tag, " done resp_valid"}, 64'(resp_valid), 64'd0);
    next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b11;
    resp_ready = 2'b00;
    req0_a = 64'd1; req0_b = 64'd2; req0_cntrl = 3'b010;
    req1_a = 64'd3; req1_b = 64'd4; req1_cntrl = 3'b010;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst req_ready", 64'(req_ready), 64'd0);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst result", resp_result, 64'd0);
    check("rst flags", 64'(resp_flags), 64'd0);
    check("rst alu_a", alu_a, 64'd0);
    check("rst alu_cntrl", 64'(alu_cntrl), 64'd0);
    next_cycle();
    reset = 1'b0;
    req_valid = 2'b00;

    // T1 / T2
    do_txn(0, 3'b010, 64'd5, 64'd3, 64'd8, 4'b0000, "T1");
    do_txn(1, 3'b011, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, "T2");

    // T3: both always valid, alternating grants starting with requester 0
    req0_a = 64'd100; req0_b = 64'd1; req0_cntrl = 3'b010;
    req1_a = 64'd100; req1_b = 64'd1; req1_cntrl = 3'b011;
    req_valid = 2'b11;
    resp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("T3 grant", 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
      next_cycle();
      @(negedge clk);
      check("T3 exec req_ready", 64'(req_ready), 64'd0);
      next_cycle();
      @(negedge clk);
      check("T3 resp_valid", 64'(resp_valid), (i % 2 == 0) ? 64'd1 : 64'd2);
      check("T3 result", resp_result, (i % 2 == 0) ? 64'd101 : 64'd99);
      next_cycle();
    end
    req_valid = 2'b00;
    resp_ready = 2'b00;
    next_cycle();

    // T4: stalled response; non-owner resp_ready must be ignored
    req0_a = 64'd7; req0_b = 64'd7; req0_cntrl = 3'b011;
    req_valid = 2'b01;
    @(negedge clk);
    check("T4 req_ready", 64'(req_ready), 64'd1);
    next_cycle();
    req_valid = 2'b11;
    resp_ready = 2'b10;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("T4 hold resp_valid", 64'(resp_valid), 64'd1);
      check("T4 hold result", resp_result, 64'd0);
      check("T4 hold flags", 64'(resp_flags), 64'b0101);
      check("T4 hold busy", 64'(busy), 64'd1);
      check("T4 hold req_ready", 64'(req_ready), 64'd0);
      next_cycle();
    end
    req_valid = 2'b00;
    resp_ready = 2'b01;
    next_cycle();
    resp_ready = 2'b00;
    @(negedge clk);
    check("T4 release busy", 64'(busy), 64'd0);
    next_cycle();

    // Opcode forwarding: pass B and an undefined code
    do_txn(1, 3'b000, 64'd9, 64'h1234, 64'h1234, 4'b0000, "PASSB");
    do_txn(1, 3'b111, 64'd9, 64'd9, 64'd0, 4'b0100, "UNDEF");

    // T5: signed overflow
    do_txn(0, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1010, "T5");

    // T6: reset in EXEC drops the transaction and restores tie priority
    req0_a = 64'd5; req0_b = 64'd3; req0_cntrl = 3'b010;
    req_valid = 2'b01;
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    check("T6 in exec", 64'(busy), 64'd1);
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    check("T6 resp_valid", 64'(resp_valid), 64'd0);
    check("T6 busy", 64'(busy), 64'd0);
    check("T6 result", resp_result, 64'd0);
    check("T6 flags", 64'(resp_flags), 64'd0);
    check("T6 alu_a", alu_a, 64'd0);
    check("T6 alu_b", alu_b, 64'd0);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("T6 no response", 64'(resp_valid), 64'd0);
      next_cycle();
    end
    req_valid = 2'b11;
    @(negedge clk);
    check("T6 tie grant", 64'(req_ready), 64'd1);
    next_cycle();
    req_valid = 2'b00;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
